// File: rtl/uart_tx_fifo_param_if.sv
// Host-side FIFO port of the UART transmitter: write strobe/data, flush and FIFO status.
interface uart_tx_fifo_param_if #(
   parameter int FIFO_AW = 4
);
   logic             wr_en;
   logic [7:0]       wr_data;
   logic             fifo_flush;
   logic             txrdy;
   logic             fifo_empty;
   logic [FIFO_AW:0] fifo_count;
   logic             overflow;

   modport master (
      output wr_en, wr_data, fifo_flush,
      input  txrdy, fifo_empty, fifo_count, overflow
   );

   modport slave (
      input  wr_en, wr_data, fifo_flush,
      output txrdy, fifo_empty, fifo_count, overflow
   );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with integrated TX FIFO; 5-8 data bits, optional parity, 1/2 stop bits,
// break, and back-to-back frames with no idle bit between them.
module uart_tx_fifo_param #(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 xmit_pulse,
   input  logic [1:0]           char_len,
   input  logic                 parity_en,
   input  logic                 odd_n_even,
   input  logic                 two_stop,
   input  logic                 break_en,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done,
   uart_tx_fifo_param_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

   typedef struct packed {
      logic [1:0] char_len;
      logic       parity_en;
      logic       odd_n_even;
      logic       two_stop;
   } cfg_t;

   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               full, empty, push, pop;

   state_e             state_q, state_d;
   cfg_t               cfg_q, cfg_d;
   logic [7:0]         shift_q, shift_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic               tx_q, tx_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;

   logic               can_start, last_bit, par_bit;
   logic [2:0]         nxt_bit;
   logic [7:0]         data_mask;

   // ---------------- FIFO ----------------
   assign full  = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.wr_en & ~full & ~bus.fifo_flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
      rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
      count_d  = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      ovf_d    = bus.wr_en & full;
      if (bus.fifo_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Storage is not reset; pointer reset alone discards the contents.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.wr_data;
   end

   // ---------------- frame helpers ----------------
   assign can_start = ~empty & ~break_en;
   assign last_bit  = (bit_cnt_q == {1'b1, cfg_q.char_len});
   assign nxt_bit   = bit_cnt_q + 3'd1;
   assign data_mask = 8'hFF >> (2'd3 - cfg_q.char_len);
   assign par_bit   = (^(shift_q & data_mask)) ^ cfg_q.odd_n_even;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      if (xmit_pulse) begin
         unique case (state_q)
            IDLE:    if (can_start) state_d = START;
            START:   state_d = DATA;
            DATA:    if (last_bit) state_d = cfg_q.parity_en ? PARITY : STOP1;
            PARITY:  state_d = STOP1;
            STOP1:   if (cfg_q.two_stop) state_d = STOP2;
                     else                state_d = can_start ? START : IDLE;
            STOP2:   state_d = can_start ? START : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------- outputs / datapath ----------------
   always_comb begin
      tx_d      = tx_q;
      shift_d   = shift_q;
      cfg_d     = cfg_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      pop       = 1'b0;
      if (state_q == IDLE) tx_d = ~break_en;
      if (xmit_pulse) begin
         unique case (state_q)
            IDLE: if (can_start) begin
               pop  = 1'b1;
               tx_d = 1'b0;
            end
            START: tx_d = shift_q[0];
            DATA: begin
               if (last_bit) begin
                  tx_d = cfg_q.parity_en ? par_bit : 1'b1;
               end else begin
                  tx_d      = shift_q[nxt_bit];
                  bit_cnt_d = nxt_bit;
               end
            end
            PARITY: tx_d = 1'b1;
            STOP1, STOP2: begin
               if (state_q == STOP1 && cfg_q.two_stop) begin
                  tx_d = 1'b1;
               end else begin
                  // Frame end: chain straight into the next start bit when data is waiting.
                  done_d = 1'b1;
                  pop    = can_start;
                  tx_d   = can_start ? 1'b0 : ~break_en;
               end
            end
            default: tx_d = 1'b1;
         endcase
      end
      if (pop) begin
         shift_d   = mem_q[rd_ptr_q];
         cfg_d     = '{char_len: char_len, parity_en: parity_en,
                       odd_n_even: odd_n_even, two_stop: two_stop};
         bit_cnt_d = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         cfg_q     <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         cfg_q     <= cfg_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign tx             = tx_q;
   assign tx_busy        = (state_q != IDLE);
   assign tx_done        = done_q;
   assign bus.txrdy      = ~full;
   assign bus.fifo_empty = empty;
   assign bus.fifo_count = count_q;
   assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: directed scenarios plus random traffic, checked every clock
// against a frame-level model (byte queue + list of line levels for the frame on the wire).
module tb_uart_tx_fifo_param;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic       clk = 1'b0;
   logic       reset, xmit_pulse;
   logic [1:0] char_len;
   logic       parity_en, odd_n_even, two_stop, break_en;
   logic       tx, tx_busy, tx_done;

   int checks = 0;
   int errors = 0;

   uart_tx_fifo_param_if #(.FIFO_AW(AW)) bus ();

   uart_tx_fifo_param #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
      .clk(clk), .reset(reset), .xmit_pulse(xmit_pulse),
      .char_len(char_len), .parity_en(parity_en), .odd_n_even(odd_n_even),
      .two_stop(two_stop), .break_en(break_en),
      .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .bus(bus)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [7:0] mq[$];
   logic       bq[$];
   logic       ebusy, etx, edone, eovf;
   logic [31:0] seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock with the given inputs; advance the model, then compare every output.
   task automatic tick(input logic p, input logic wr, input logic [7:0] d,
                       input logic fl, input logic rst);
      logic       full, empty;
      logic [7:0] b;
      int         len;
      logic       par;
      xmit_pulse     = p;
      bus.wr_en      = wr;
      bus.wr_data    = d;
      bus.fifo_flush = fl;
      reset          = rst;
      if (rst) begin
         mq.delete(); bq.delete();
         ebusy = 0; etx = 1; edone = 0; eovf = 0;
      end else begin
         full  = (mq.size() == DEPTH);
         empty = (mq.size() == 0);
         eovf  = wr & full;
         edone = 0;
         if (p) begin
            if (ebusy && bq.size() > 0) etx = bq.pop_front();
            else begin
               if (ebusy) edone = 1;
               if (!empty && !break_en) begin
                  b   = mq.pop_front();
                  len = 5 + int'(char_len);
                  par = odd_n_even;
                  bq.push_back(1'b0);
                  for (int i = 0; i < len; i++) begin
                     bq.push_back(b[i]);
                     par ^= b[i];
                  end
                  if (parity_en) bq.push_back(par);
                  bq.push_back(1'b1);
                  if (two_stop) bq.push_back(1'b1);
                  etx   = bq.pop_front();
                  ebusy = 1;
               end else ebusy = 0;
            end
         end
         if (!ebusy) etx = ~break_en;
         if (fl) mq.delete();
         else if (wr && !full) mq.push_back(d);
      end
      @(posedge clk);
      #1;
      xmit_pulse = 0; bus.wr_en = 0; bus.fifo_flush = 0; reset = 0;
      if (p) seen = {seen[30:0], tx};
      chk("tx",         32'(tx),             32'(etx));
      chk("tx_busy",    32'(tx_busy),        32'(ebusy));
      chk("tx_done",    32'(tx_done),        32'(edone));
      chk("overflow",   32'(bus.overflow),   32'(eovf));
      chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
      chk("fifo_empty", 32'(bus.fifo_empty), 32'(mq.size() == 0));
      chk("txrdy",      32'(bus.txrdy),      32'(mq.size() != DEPTH));
   endtask

   task automatic wr(input logic [7:0] d);
      tick(1'b0, 1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic run_pulses(input int n, input int per);
      for (int i = 0; i < n; i++) begin
         tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
         for (int k = 1; k < per; k++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      end
   endtask

   task automatic set_cfg(input logic [1:0] cl, input logic pe, input logic odd, input logic ts);
      char_len = cl; parity_en = pe; odd_n_even = odd; two_stop = ts;
   endtask

   initial begin
      xmit_pulse = 0; reset = 1; break_en = 0; seen = '0;
      bus.wr_en = 0; bus.wr_data = '0; bus.fifo_flush = 0;
      set_cfg(2'd3, 1'b0, 1'b0, 1'b0);

      // reset state
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // 8N1, 0xA5, 16-clock bit period
      wr(8'hA5);
      chk("cnt_after_wr", 32'(bus.fifo_count), 32'd1);
      seen = '0;
      run_pulses(11, 16);
      chk("seq_8n1", seen[10:0], 32'b01010010111);

      // 7E2 with bit 7 set (must not appear), then 7O2
      set_cfg(2'd2, 1'b1, 1'b0, 1'b1);
      wr(8'hB5);
      seen = '0;
      run_pulses(12, 4);
      chk("seq_7e2", seen[11:0], 32'b010101100111);
      odd_n_even = 1'b1;
      wr(8'h35);
      seen = '0;
      run_pulses(12, 4);
      chk("seq_7o2", seen[11:0], 32'b010101101111);

      // three back-to-back 5N1 frames
      set_cfg(2'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) wr(8'($urandom));
      run_pulses(22, 3);

      // fill, overflow, then write+pop at count 3
      for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
      chk("full_count", 32'(bus.fifo_count), 32'd4);
      tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      run_pulses(6, 1);
      tick(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
      chk("wr_pop_cnt", 32'(bus.fifo_count), 32'd3);
      run_pulses(30, 2);

      // break mid-frame: frame completes, line held low, pending byte waits
      wr(8'h13); wr(8'h0E);
      run_pulses(3, 2);
      break_en = 1'b1;
      run_pulses(8, 2);
      chk("brk_low", 32'(tx), 32'd0);
      chk("brk_pend", 32'(bus.fifo_count), 32'd1);
      break_en = 1'b0;
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("brk_release", 32'(tx), 32'd1);
      run_pulses(8, 2);

      // reset mid-DATA
      wr(8'h5A); wr(8'h66);
      run_pulses(3, 2);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_cnt", 32'(bus.fifo_count), 32'd0);

      // flush during a frame: frame still finishes
      wr(8'h21); wr(8'h22); wr(8'h23);
      run_pulses(2, 2);
      tick(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
      chk("flush_cnt", 32'(bus.fifo_count), 32'd0);
      chk("flush_busy", 32'(tx_busy), 32'd1);
      run_pulses(6, 2);
      chk("flush_done", 32'(tx_busy), 32'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) break_en = ~break_en;
         if ($urandom_range(0, 29) == 0)
            set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0), 8'($urandom),
              1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 999) == 0));
      end
      break_en = 1'b0;
      run_pulses(60, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
